// File: rtl/sq_recon.sv
// Sequential square reconstruction: d = q*q + r via an LSB-first shift-add multiplier.
// Optional non-canonical remainder flag enabled by defining SQ_RECON_ERR_EN.
module sq_recon #(
    parameter int unsigned Q_WIDTH = 11,
    parameter int unsigned R_WIDTH = 12,
    parameter int unsigned D_WIDTH = 23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_vaild,
    output logic               o_ready,
    input  logic [Q_WIDTH-1:0] data_q,
    input  logic [R_WIDTH-1:0] data_r,
    output logic               o_vaild,
    input  logic               i_ready,
    output logic [D_WIDTH-1:0] data_d,
    output logic               o_err
);

    localparam int unsigned CNT_W = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;
    localparam int unsigned CMP_W = R_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ADD,
        DONE
    } state_t;

    state_t             state, state_n;
    logic [Q_WIDTH-1:0] q_reg, q_reg_n;
    logic [R_WIDTH-1:0] r_reg, r_reg_n;
    logic [D_WIDTH-1:0] acc, acc_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               o_ready_n;
    logic               o_vaild_n;
    logic [D_WIDTH-1:0] data_d_n;
`ifdef SQ_RECON_ERR_EN
    logic               err_q, err_n;
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            q_reg   <= '0;
            r_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            o_ready <= 1'b1;
            o_vaild <= 1'b0;
            data_d  <= '0;
`ifdef SQ_RECON_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            q_reg   <= q_reg_n;
            r_reg   <= r_reg_n;
            acc     <= acc_n;
            cnt     <= cnt_n;
            o_ready <= o_ready_n;
            o_vaild <= o_vaild_n;
            data_d  <= data_d_n;
`ifdef SQ_RECON_ERR_EN
            err_q   <= err_n;
`endif
        end
    end

    // Next-state and next-output logic; outputs are registered one edge ahead
    always_comb begin
        state_n   = state;
        q_reg_n   = q_reg;
        r_reg_n   = r_reg;
        acc_n     = acc;
        cnt_n     = cnt;
        o_ready_n = o_ready;
        o_vaild_n = o_vaild;
        data_d_n  = data_d;
`ifdef SQ_RECON_ERR_EN
        err_n     = err_q;
`endif
        case (state)
            IDLE: begin
                if (i_vaild) begin
                    q_reg_n   = data_q;
                    r_reg_n   = data_r;
                    acc_n     = '0;
                    cnt_n     = '0;
                    o_ready_n = 1'b0;
                    state_n   = MUL;
                end
            end
            MUL: begin
                if (q_reg[cnt]) begin
                    acc_n = acc + (D_WIDTH'(q_reg) << cnt);
                end
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(Q_WIDTH - 1)) begin
                    state_n = ADD;
                end
            end
            ADD: begin
                acc_n     = acc + D_WIDTH'(r_reg);
                data_d_n  = acc + D_WIDTH'(r_reg);
                o_vaild_n = 1'b1;
`ifdef SQ_RECON_ERR_EN
                // A true isqrt remainder never exceeds 2*q
                err_n     = CMP_W'(r_reg) > (CMP_W'(q_reg) << 1);
`endif
                state_n   = DONE;
            end
            DONE: begin
                if (i_ready) begin
                    o_vaild_n = 1'b0;
                    data_d_n  = '0;
                    o_ready_n = 1'b1;
`ifdef SQ_RECON_ERR_EN
                    err_n     = 1'b0;
`endif
                    state_n   = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef SQ_RECON_ERR_EN
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_sq_recon.sv
// Self-checking bench for sq_recon: timeline model plus directed literal checks.
module tb_sq_recon;

    localparam int unsigned QW = 11;
    localparam int unsigned RW = 12;
    localparam int unsigned DW = 23;
`ifdef SQ_RECON_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          i_vaild = 1'b0;
    logic          i_ready = 1'b0;
    logic [QW-1:0] data_q  = '0;
    logic [RW-1:0] data_r  = '0;
    logic          o_ready;
    logic          o_vaild;
    logic          o_err;
    logic [DW-1:0] data_d;

    int     checks  = 0;
    int     errors  = 0;
    longint cyc     = 0;
    bit     started = 1'b0;

    sq_recon #(.Q_WIDTH(QW), .R_WIDTH(RW), .D_WIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_vaild (i_vaild),
        .o_ready (o_ready),
        .data_q  (data_q),
        .data_r  (data_r),
        .o_vaild (o_vaild),
        .i_ready (i_ready),
        .data_d  (data_d),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: busy for QW+1 edges after acceptance, then result held until i_ready
    int     m_cnt   = 0;
    bit     m_ready = 1'b1;
    bit     m_valid = 1'b0;
    bit     m_err   = 1'b0;
    longint m_d     = 0;
    longint p_d     = 0;
    bit     p_err   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt   <= 0;
            m_ready <= 1'b1;
            m_valid <= 1'b0;
            m_d     <= 0;
            m_err   <= 1'b0;
        end else if (m_valid) begin
            if (i_ready) begin
                m_valid <= 1'b0;
                m_d     <= 0;
                m_err   <= 1'b0;
                m_ready <= 1'b1;
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_valid <= 1'b1;
                m_d     <= p_d;
                m_err   <= p_err;
            end
        end else if (i_vaild) begin
            m_cnt   <= QW + 1;
            m_ready <= 1'b0;
            p_d     <= longint'(data_q) * longint'(data_q) + longint'(data_r);
            p_err   <= ERR_EN && (int'(data_r) > 2 * int'(data_q));
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_o_ready", 64'(o_ready), 64'(m_ready));
            chk("model_o_vaild", 64'(o_vaild), 64'(m_valid));
            chk("model_data_d",  64'(data_d),  64'(m_d));
            chk("model_o_err",   64'(o_err),   64'(m_err));
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge
    task automatic send(input int q, input int r, output longint acc_cyc);
        int w = 0;
        while (!o_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_before_send", 64'(o_ready), 64'd1);
        i_vaild = 1'b1;
        data_q  = QW'(q);
        data_r  = RW'(r);
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        i_vaild = 1'b0;
        data_q  = QW'($urandom);
        data_r  = RW'($urandom);
    endtask

    task automatic wait_valid(input bit chk_busy, output int n);
        n = 0;
        while (!o_vaild && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (chk_busy) chk("busy_o_ready", 64'(o_ready), 64'd0);
        end
    endtask

    longint a0, a1;
    int     n;

    initial begin
        #1 rst = 1'b1;
        #20;
        @(posedge clk); #1;
        chk("reset_o_ready", 64'(o_ready), 64'd1);
        chk("reset_o_vaild", 64'(o_vaild), 64'd0);
        chk("reset_data_d",  64'(data_d),  64'd0);
        rst     = 1'b0;
        started = 1'b1;

        // q=0, r=0 with result held one extra cycle
        send(0, 0, a0);
        wait_valid(1'b1, n);
        chk("lat_q0", 64'(n), 64'd12);
        chk("d_q0",   64'(data_d), 64'd0);
        chk("err_q0", 64'(o_err),  64'd0);
        i_ready = 1'b1;
        @(posedge clk); #1;

        // back-to-back beats at minimum spacing
        send(5, 3, a0);
        wait_valid(1'b0, n);
        chk("lat_q5",  64'(n), 64'd12);
        chk("d_q5_r3", 64'(data_d), 64'd28);
        @(posedge clk); #1;
        chk("ready_back", 64'(o_ready), 64'd1);
        chk("valid_one_cycle", 64'(o_vaild), 64'd0);
        send(7, 0, a1);
        chk("ii_spacing", 64'(a1 - a0), 64'd14);
        wait_valid(1'b0, n);
        chk("d_q7", 64'(data_d), 64'd49);
        @(posedge clk); #1;

        // maximum product
        send(2047, 4094, a0);
        wait_valid(1'b0, n);
        chk("d_max",   64'(data_d), 64'd4194303);
        chk("err_max", 64'(o_err),  64'd0);
        @(posedge clk); #1;

        // non-canonical remainder
        send(3, 7, a0);
        wait_valid(1'b0, n);
        chk("d_q3_r7",   64'(data_d), 64'd16);
        chk("err_q3_r7", 64'(o_err),  64'(ERR_EN));
        @(posedge clk); #1;

        // backpressure with a dropped beat
        i_ready = 1'b0;
        send(10, 1, a0);
        wait_valid(1'b0, n);
        for (int k = 0; k < 5; k++) begin
            chk("bp_data_d",  64'(data_d),  64'd101);
            chk("bp_o_vaild", 64'(o_vaild), 64'd1);
            if (k == 1) begin
                i_vaild = 1'b1;
                data_q  = QW'(9);
                data_r  = RW'(0);
            end
            @(posedge clk); #1;
            i_vaild = 1'b0;
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(o_vaild), 64'd0);
        chk("bp_release_ready", 64'(o_ready), 64'd1);
        chk("bp_release_d",     64'(data_d),  64'd0);
        repeat (15) @(posedge clk);
        #1;
        chk("dropped_beat_idle", 64'(o_vaild), 64'd0);

        // reset in the middle of MUL
        send(100, 5, a0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(o_ready), 64'd1);
        chk("mid_rst_valid", 64'(o_vaild), 64'd0);
        chk("mid_rst_d",     64'(data_d),  64'd0);
        chk("mid_rst_err",   64'(o_err),   64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk("no_valid_after_rst", 64'(o_vaild), 64'd0);
        end
        send(100, 0, a0);
        wait_valid(1'b0, n);
        chk("d_q100", 64'(data_d), 64'd10000);
        chk("lat_q100", 64'(n), 64'd12);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sq_recon.md
# sq_recon

Sequential square-reconstruction unit. It takes an integer root `q` and remainder `r` and rebuilds the radicand `d = q*q + r`. This is the inverse of the pipelined integer square-root stage in the math_module path. It sits on the consumer side of a root/remainder stream and is used for self-check and back-conversion of tracker distance metrics. The squaring uses a shift-add multiplier driven by a small FSM, with a valid/ready handshake on both ports.

## Interface
- `Q_WIDTH`, default 11: root width.
- `R_WIDTH`, default 12: remainder width. Must be `Q_WIDTH+1`.
- `D_WIDTH`, default 23: result width. Must be `2*Q_WIDTH+1`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_vaild` in 1: input beat valid.
- `o_ready` out 1: unit can accept an input beat.
- `data_q` in `Q_WIDTH`: root operand.
- `data_r` in `R_WIDTH`: remainder operand.
- `o_vaild` out 1: result valid.
- `i_ready` in 1: downstream accepts result.
- `data_d` out `D_WIDTH`: reconstructed radicand.
- `o_err` out 1: non-canonical remainder flag; see Configuration.

## Operation
- States: IDLE, MUL, ADD, DONE.
- IDLE:
  - `o_ready`=1.
  - On `i_vaild`=1, latch `data_q` into `q_reg` and `data_r` into `r_reg`, clear `acc` and `cnt`, and go to MUL.
- MUL: one multiplier bit per cycle, LSB first.
  - If `q_reg[cnt]`=1, `acc <= acc + (q_reg << cnt)`, zero-extended to `D_WIDTH`.
  - `cnt` increments each cycle.
  - After `cnt == Q_WIDTH-1` is processed, go to ADD.
- ADD:
  - `acc <= acc + r_reg`, zero-extended. No wrap is possible: max is (2^Q_WIDTH-1)^2 + 2^R_WIDTH-1 < 2^D_WIDTH.
  - Evaluate the error flag, then go to DONE.
- DONE:
  - `o_vaild`=1; `data_d` = `acc`; `o_err` is valid.
  - `data_d` and `o_err` are held stable while `i_ready`=0.
  - On `i_ready`=1, go to IDLE. `o_vaild`, `data_d` and `o_err` clear to 0 at that edge.
- `o_ready`=0 in MUL, ADD and DONE. Any `i_vaild` pulse there is dropped: not queued, no state change.
- Outside DONE, `data_d`=0, `o_err`=0 and `o_vaild`=0.
- An input change after acceptance has no effect, because operands are latched.

## Timing
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - `o_ready`=1.
  - `o_vaild`=0, `data_d`=0, `o_err`=0.
  - `acc`, `cnt`, `q_reg` and `r_reg` clear to 0.
- Reset mid-MUL or mid-DONE aborts the operation; no result is ever produced for it.
- Latency: input accepted at edge E0; `o_vaild` rises after edge E0+`Q_WIDTH`+1. With defaults that is 12 cycles.
- Initiation interval: `Q_WIDTH`+3 cycles minimum with `i_ready` held high (14 with defaults).
- A new beat is accepted no earlier than the cycle after the DONE→IDLE edge.
- `i_vaild` and `i_ready` are sampled only on rising edges. No combinational path runs from either input to either output.
- Special values:
  - `q`=0 completes in the same cycle count; `d = r`.
  - `q`=all-ones is the maximum product; it must not truncate.

## Configuration
- Macro: `SQ_RECON_ERR_EN`.
- Defined:
  - In ADD, `o_err` is set to 1 when `r_reg > 2*q_reg`, i.e. the remainder is not one a true isqrt could produce.
  - The comparison is done at `R_WIDTH+1` bits.
  - `data_d` is still produced normally.
- Undefined:
  - The comparator is not instantiated.
  - `o_err` is tied to 0.
  - The port remains present.

## Test plan
- Reset then `q`=0, `r`=0:
  - expect `d`=0 and `o_err`=0.
  - `o_vaild` is high exactly 12 cycles after acceptance.
  - `o_ready` is low throughout.
- `q`=5, `r`=3 with `i_ready`=1:
  - expect `d`=28 for one cycle.
  - `o_ready` is back to 1 on the next cycle.
  - A second beat, `q`=7, `r`=0, gives `d`=49 at 14-cycle spacing.
- `q`=2047, `r`=4094: expect `d`=4194303 and `o_err`=0.
- `q`=3, `r`=7:
  - expect `d`=16.
  - `o_err`=1 with `SQ_RECON_ERR_EN`, 0 without.
- Backpressure:
  - Result `q`=10, `r`=1 (`d`=101) with `i_ready` low for 5 cycles: `data_d` holds 101 and `o_vaild` holds 1.
  - A beat with `q`=9 pulsed during this window is ignored.
  - `i_ready` high then returns to IDLE.
- Assert `rst` mid-MUL, at cycle 4 of `q`=100:
  - All outputs go to 0 immediately; `o_ready`=1.
  - No `o_vaild` follows.
  - The next beat, `q`=100, `r`=0, yields `d`=10000.
